// File: rtl/cw_transceiver_tx.sv
// ---------------------------------------------------------------------------
// cw_transceiver_tx
// Morse-code (CW) transmitter keyer for the DE-board transceiver.
//
// Four active-low pushbuttons each queue one preset character (E, T, A, N).
// Two slide switches override the buttons: SW[1]=0 sends a continuous
// square wave on the key line, SW[0]=0 repeatedly sends the callsign W8EDU.
// Callsign mode has priority over clock mode, which has priority over keys.
//
// Ports:
//    CLK     in   1  system clock (50 MHz nominal)
//    RST     in   1  asynchronous active-high reset
//    KEY     in   4  pushbuttons, active-low, asynchronous
//    SW      in  10  slide switches; SW[0]=0 callsign, SW[1]=0 clock, rest unused
//    GPIO_1  out 36  [0] key line, [1] gated sidetone, [35:2] tied low
//    HEX0    out  7  seven-segment display, active-low, gfedcba
//
// Optional feature macro: DEBOUNCE_EN
//    When defined, each synchronized key must hold a new level for
//    DEBOUNCE_CYCLES clocks before it is accepted. Switches are never debounced.
// ---------------------------------------------------------------------------
module cw_transceiver_tx #(
   parameter int UNIT_CYCLES     = 2500000,
   parameter int TONE_DIV        = 25000,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  KEY,
   input  logic [9:0]  SW,
   output logic [35:0] GPIO_1,
   output logic [6:0]  HEX0
);

   localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
   localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
   localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

   localparam logic [6:0] HEX_BLANK = 7'b1111111;
   localparam logic [6:0] HEX_DASH  = 7'b0111111;
   localparam logic [6:0] HEX_CALL  = 7'b1000110;

   typedef enum logic [1:0] {IDLE, ELEM_ON, ELEM_GAP, CHAR_GAP} SeqState;
   typedef enum logic [1:0] {MODE_KEYS, MODE_CLOCK, MODE_CALL} Mode;

   logic [3:0]    keySync1, keySync2;
   logic [1:0]    swSync1, swSync2;
   logic [3:0]    keyLevel, keyPrev, press;
   logic [3:0]    pending, pickMask;
   logic [1:0]    pickIdx;
   logic          pickValid;
   logic [14:0]   keyPat;
   logic [7:0]    firstCall, nextCall;
   logic [2:0]    nextIdx;
   logic [UW-1:0] unitCnt;
   logic          unitTick;
   logic [TW-1:0] toneCnt;
   logic          toneBit;
   SeqState       state;
   Mode           modeReg, modeNow;
   logic          keyLine, keyOut;
   logic [4:0]    elemBits;
   logic [2:0]    elemLeft, remain, charIdx;
   logic [6:0]    charHex;
   logic          unusedSw;

   assign unusedSw = ^SW[9:2];

   // Key character table: {hex pattern, element count, element bits}.
   // Element bits are consumed LSB first; a 1 is a dash, a 0 is a dot.
   function automatic logic [14:0] keyPattern(input logic [1:0] idx);
      case (idx)
         2'd0:    keyPattern = {7'b0000110, 3'd1, 5'b00000};
         2'd1:    keyPattern = {7'b0000111, 3'd1, 5'b00001};
         2'd2:    keyPattern = {7'b0001000, 3'd2, 5'b00010};
         default: keyPattern = {7'b0101011, 3'd2, 5'b00001};
      endcase
   endfunction

   // Callsign table W 8 E D U in the same {count, bits} packing.
   function automatic logic [7:0] callPattern(input logic [2:0] idx);
      case (idx)
         3'd0:    callPattern = {3'd3, 5'b00110};
         3'd1:    callPattern = {3'd5, 5'b00111};
         3'd2:    callPattern = {3'd1, 5'b00000};
         3'd3:    callPattern = {3'd3, 5'b00001};
         default: callPattern = {3'd3, 5'b00100};
      endcase
   endfunction

   // Two-flop synchronizers for the buttons and the two mode switches. They
   // reset to the released / not-selected level so leaving reset never
   // looks like a press or a mode request.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         keySync1 <= 4'hF;
         keySync2 <= 4'hF;
         swSync1  <= 2'b11;
         swSync2  <= 2'b11;
      end else begin
         keySync1 <= KEY;
         keySync2 <= keySync1;
         swSync1  <= SW[1:0];
         swSync2  <= swSync1;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [DW-1:0] debounceCnt [4];
   logic [3:0]    keyStable;

   // Each key only adopts a new level after it has differed from the
   // accepted level for DEBOUNCE_CYCLES clocks in a row; any return to the
   // accepted level restarts the count, so short glitches vanish.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         keyStable <= 4'hF;
         for (int i = 0; i < 4; i++) begin
            debounceCnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (keySync2[i] == keyStable[i]) begin
               debounceCnt[i] <= '0;
            end else if (debounceCnt[i] == DEB_LAST) begin
               keyStable[i]   <= keySync2[i];
               debounceCnt[i] <= '0;
            end else begin
               debounceCnt[i] <= debounceCnt[i] + DW'(1);
            end
         end
      end
   end

   assign keyLevel = keyStable;
`else
   localparam int unusedDebounce = DEBOUNCE_CYCLES;

   assign keyLevel = keySync2;
`endif

   // Press detection: a press is a 1->0 transition of the (optionally
   // debounced) synchronized key level.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         keyPrev <= 4'hF;
      end else begin
         keyPrev <= keyLevel;
      end
   end

   assign press = keyPrev & ~keyLevel;

   // Free-running sidetone square wave; it only reaches the pin when the
   // key line is up.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         toneCnt <= '0;
         toneBit <= 1'b0;
      end else if (toneCnt == TONE_LAST) begin
         toneCnt <= '0;
         toneBit <= ~toneBit;
      end else begin
         toneCnt <= toneCnt + TW'(1);
      end
   end

   // Mode request from the synchronized switches, callsign winning over
   // clock, plus the lowest-index pending key and the character tables
   // the sequencer may load this cycle.
   always_comb begin
      modeNow = MODE_KEYS;
      if (!swSync2[0]) begin
         modeNow = MODE_CALL;
      end else if (!swSync2[1]) begin
         modeNow = MODE_CLOCK;
      end

      pickIdx  = 2'd0;
      pickMask = 4'b0000;
      if (pending[0]) begin
         pickIdx  = 2'd0;
         pickMask = 4'b0001;
      end else if (pending[1]) begin
         pickIdx  = 2'd1;
         pickMask = 4'b0010;
      end else if (pending[2]) begin
         pickIdx  = 2'd2;
         pickMask = 4'b0100;
      end else if (pending[3]) begin
         pickIdx  = 2'd3;
         pickMask = 4'b1000;
      end
      pickValid = |pending;
      keyPat    = keyPattern(pickIdx);

      nextIdx   = (charIdx == 3'd4) ? 3'd0 : charIdx + 3'd1;
      nextCall  = callPattern(nextIdx);
      firstCall = callPattern(3'd0);
   end

   assign unitTick = (unitCnt == UNIT_LAST);

   // Main sequencer. A mode change aborts whatever is in flight: entering
   // callsign mode loads W on a fresh unit, any other change parks in IDLE
   // with the key up. Clock mode just toggles the key line every unit.
   // Otherwise the FSM walks the loaded elements one unit tick at a time.
   // At the end of a character gap the next character (queued key or next
   // callsign letter) is loaded directly so the inter-character gap is
   // exactly three units; the word gap after U is seven.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         modeReg  <= MODE_KEYS;
         state    <= IDLE;
         pending  <= '0;
         unitCnt  <= '0;
         keyLine  <= 1'b0;
         elemBits <= '0;
         elemLeft <= '0;
         remain   <= '0;
         charIdx  <= '0;
         charHex  <= HEX_BLANK;
      end else begin
         unitCnt <= unitTick ? '0 : unitCnt + UW'(1);
         if (modeNow != modeReg) begin
            modeReg <= modeNow;
            pending <= '0;
            unitCnt <= '0;
            if (modeNow == MODE_CALL) begin
               state    <= ELEM_ON;
               keyLine  <= 1'b1;
               charIdx  <= 3'd0;
               elemLeft <= firstCall[7:5];
               elemBits <= firstCall[4:0];
               remain   <= firstCall[0] ? 3'd3 : 3'd1;
            end else begin
               state   <= IDLE;
               keyLine <= 1'b0;
            end
         end else if (modeReg == MODE_CLOCK) begin
            pending <= '0;
            state   <= IDLE;
            if (unitTick) begin
               keyLine <= ~keyLine;
            end
         end else begin
            if (modeReg == MODE_KEYS) begin
               pending <= pending | press;
            end else begin
               pending <= '0;
            end
            case (state)
               IDLE: begin
                  if (modeReg == MODE_KEYS && pickValid) begin
                     state    <= ELEM_ON;
                     keyLine  <= 1'b1;
                     unitCnt  <= '0;
                     pending  <= (pending | press) & ~pickMask;
                     charHex  <= keyPat[14:8];
                     elemLeft <= keyPat[7:5];
                     elemBits <= keyPat[4:0];
                     remain   <= keyPat[0] ? 3'd3 : 3'd1;
                  end
               end
               ELEM_ON: begin
                  if (unitTick) begin
                     if (remain == 3'd1) begin
                        keyLine  <= 1'b0;
                        elemBits <= elemBits >> 1;
                        elemLeft <= elemLeft - 3'd1;
                        if (elemLeft == 3'd1) begin
                           state  <= CHAR_GAP;
                           remain <= (modeReg == MODE_CALL && charIdx == 3'd4) ? 3'd7 : 3'd3;
                        end else begin
                           state  <= ELEM_GAP;
                           remain <= 3'd1;
                        end
                     end else begin
                        remain <= remain - 3'd1;
                     end
                  end
               end
               ELEM_GAP: begin
                  if (unitTick) begin
                     state   <= ELEM_ON;
                     keyLine <= 1'b1;
                     remain  <= elemBits[0] ? 3'd3 : 3'd1;
                  end
               end
               CHAR_GAP: begin
                  if (unitTick) begin
                     if (remain != 3'd1) begin
                        remain <= remain - 3'd1;
                     end else if (modeReg == MODE_CALL) begin
                        state    <= ELEM_ON;
                        keyLine  <= 1'b1;
                        charIdx  <= nextIdx;
                        elemLeft <= nextCall[7:5];
                        elemBits <= nextCall[4:0];
                        remain   <= nextCall[0] ? 3'd3 : 3'd1;
                     end else if (pickValid) begin
                        state    <= ELEM_ON;
                        keyLine  <= 1'b1;
                        pending  <= (pending | press) & ~pickMask;
                        charHex  <= keyPat[14:8];
                        elemLeft <= keyPat[7:5];
                        elemBits <= keyPat[4:0];
                        remain   <= keyPat[0] ? 3'd3 : 3'd1;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   // The key line is masked while a mode change is being taken so that it
   // drops in the very cycle the synchronized switch changes.
   assign keyOut = keyLine & (modeNow == modeReg);
   assign GPIO_1 = {34'd0, keyOut & toneBit, keyOut};

   // Display follows the registered mode, or the loaded character while the
   // sequencer is busy in key mode.
   always_comb begin
      HEX0 = HEX_BLANK;
      if (modeReg == MODE_CALL) begin
         HEX0 = HEX_CALL;
      end else if (modeReg == MODE_CLOCK) begin
         HEX0 = HEX_DASH;
      end else if (state != IDLE) begin
         HEX0 = charHex;
      end
   end

endmodule

// File: tb/tb_cw_transceiver_tx.sv
// ---------------------------------------------------------------------------
// tb_cw_transceiver_tx
// Directed bench for cw_transceiver_tx with UNIT_CYCLES=500, TONE_DIV=10.
// A background monitor timestamps every change of the key line and of HEX0
// (in clock cycles); scenarios compare the gaps between those timestamps
// against hand-derived Morse timings.
// ---------------------------------------------------------------------------
module tb_cw_transceiver_tx;

   localparam int UNIT = 500;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  KEY;
   logic [9:0]  SW;
   logic [35:0] GPIO_1;
   logic [6:0]  HEX0;

   int          checkCount = 0;
   int          passCount  = 0;
   int          cycle      = 0;
   int          edgeQ[$];
   int          hexQ[$];
   logic        lastKey    = 1'b0;
   logic [6:0]  lastHex    = 7'h7F;
   int          toneHighs;
   int          c0;
   int          lat;

   int gapsChars[11] = '{500, 1500, 1500, 1500, 500, 500, 1500, 1500, 1500, 500, 500};
   int callUnits[31] = '{1, 1, 3, 1, 3, 3,
                         3, 1, 3, 1, 3, 1, 1, 1, 1, 3,
                         1, 3,
                         3, 1, 1, 1, 1, 3,
                         1, 1, 1, 1, 3, 7,
                         1};

   cw_transceiver_tx #(
      .UNIT_CYCLES(UNIT),
      .TONE_DIV(10)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .KEY(KEY),
      .SW(SW),
      .GPIO_1(GPIO_1),
      .HEX0(HEX0)
   );

   // 50 MHz clock
   always #10 CLK = ~CLK;

   // Monitor: on every falling edge, timestamp any change of key line or HEX0
   initial begin
      forever begin
         @(negedge CLK);
         cycle++;
         if (GPIO_1[0] !== lastKey) begin
            edgeQ.push_back(cycle);
            lastKey = GPIO_1[0];
         end
         if (HEX0 !== lastHex) begin
            hexQ.push_back(cycle);
            lastHex = HEX0;
         end
      end
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checkCount++;
      if (observed == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive KEY/SW on a falling edge and hold them for a number of cycles
   task automatic applyStimulus(input logic [3:0] keyVal, input logic [9:0] swVal, input int cycles);
      KEY = keyVal;
      SW  = swVal;
      repeat (cycles) @(negedge CLK);
   endtask

   function automatic int edgeGap(input int i);
      if (i + 1 < edgeQ.size()) begin
         return edgeQ[i + 1] - edgeQ[i];
      end
      return -1;
   endfunction

   task automatic clearQueues();
      edgeQ.delete();
      hexQ.delete();
   endtask

   // Scenario sequence
   initial begin
      RST = 1'b1;
      KEY = 4'hF;
      SW  = 10'h3FF;
      repeat (5) @(negedge CLK);
      checkOutput("reset_gpio", GPIO_1, 0);
      checkOutput("reset_hex", HEX0, 7'b1111111);
      RST = 1'b0;
      repeat (10) @(negedge CLK);

      $display("[TB] scenario 1: single E");
      clearQueues();
      applyStimulus(4'b1110, 10'h3FF, 20);
      checkOutput("t1_key_on", GPIO_1[0], 1);
      checkOutput("t1_hex_e", HEX0, 7'b0000110);
      applyStimulus(4'b1111, 10'h3FF, 3000);
      checkOutput("t1_edges", edgeQ.size(), 2);
      checkOutput("t1_on_len", edgeGap(0), 500);
      checkOutput("t1_hex_changes", hexQ.size(), 2);
      checkOutput("t1_hex_len", (hexQ.size() == 2) ? hexQ[1] - hexQ[0] : -1, 2000);
      checkOutput("t1_hex_start", (hexQ.size() > 0 && edgeQ.size() > 0) ? hexQ[0] - edgeQ[0] : -1, 0);
      checkOutput("t1_idle_hex", HEX0, 7'b1111111);

      $display("[TB] scenario 2: T then A queued during T");
      clearQueues();
      applyStimulus(4'b1101, 10'h3FF, 20);
      applyStimulus(4'b1111, 10'h3FF, 200);
      toneHighs = 0;
      for (int i = 0; i < 20; i++) begin
         toneHighs += int'(GPIO_1[1]);
         @(negedge CLK);
      end
      checkOutput("t2_tone_highs", toneHighs, 10);
      checkOutput("t2_upper_zero", GPIO_1[35:2], 0);
      checkOutput("t2_hex_t", HEX0, 7'b0000111);
      applyStimulus(4'b1011, 10'h3FF, 20);
      applyStimulus(4'b1111, 10'h3FF, 7500);
      checkOutput("t2_edges", edgeQ.size(), 6);
      checkOutput("t2_t_on", edgeGap(0), 1500);
      checkOutput("t2_char_gap", edgeGap(1), 1500);
      checkOutput("t2_a_dot", edgeGap(2), 500);
      checkOutput("t2_a_elem_gap", edgeGap(3), 500);
      checkOutput("t2_a_dash", edgeGap(4), 1500);
      checkOutput("t2_hex_changes", hexQ.size(), 3);
      checkOutput("t2_hex_to_a", (hexQ.size() > 1 && edgeQ.size() > 2) ? hexQ[1] - edgeQ[2] : -1, 0);
      checkOutput("t2_hex_tail", (hexQ.size() > 2 && edgeQ.size() > 5) ? hexQ[2] - edgeQ[5] : -1, 1500);
      checkOutput("t2_sidetone_idle", GPIO_1[1], 0);

      $display("[TB] scenario 3: all four keys together");
      clearQueues();
      applyStimulus(4'b0000, 10'h3FF, 20);
      applyStimulus(4'b1111, 10'h3FF, 14000);
      checkOutput("t3_edges", edgeQ.size(), 12);
      for (int i = 0; i < 11; i++) begin
         checkOutput($sformatf("t3_gap%0d", i), edgeGap(i), gapsChars[i]);
      end
      checkOutput("t3_idle_hex", HEX0, 7'b1111111);

      $display("[TB] scenario 4: clock mode with keys pressed");
      clearQueues();
      c0 = cycle;
      applyStimulus(4'b1111, 10'h3FD, 10);
      applyStimulus(4'b0011, 10'h3FD, 20);
      applyStimulus(4'b1111, 10'h3FD, 4000);
      checkOutput("t4_hex_dash", HEX0, 7'b0111111);
      lat = (edgeQ.size() > 0) ? edgeQ[0] - c0 : -1;
      checkOutput("t4_first_edge", (lat >= 500 && lat <= 506) ? 1 : 0, 1);
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("t4_half%0d", i), edgeGap(i), 500);
      end
      applyStimulus(4'b1111, 10'h3FF, 5);
      checkOutput("t4_exit_key", GPIO_1[0], 0);
      checkOutput("t4_exit_hex", HEX0, 7'b1111111);
      clearQueues();
      applyStimulus(4'b1111, 10'h3FF, 3000);
      checkOutput("t4_no_chars", edgeQ.size(), 0);

      $display("[TB] scenario 5: callsign overriding clock mode");
      clearQueues();
      applyStimulus(4'b1111, 10'h3FD, 200);
      c0 = cycle;
      applyStimulus(4'b1111, 10'h3FC, 10);
      checkOutput("t5_hex_c", HEX0, 7'b1000110);
      applyStimulus(4'b1100, 10'h3FC, 20);
      applyStimulus(4'b1111, 10'h3FC, 30000);
      lat = (edgeQ.size() > 0) ? edgeQ[0] - c0 : -1;
      checkOutput("t5_start", (lat >= 1 && lat <= 6) ? 1 : 0, 1);
      checkOutput("t5_enough_edges", (edgeQ.size() >= 32) ? 1 : 0, 1);
      for (int i = 0; i < 31; i++) begin
         checkOutput($sformatf("t5_gap%0d", i), edgeGap(i), callUnits[i] * UNIT);
      end
      applyStimulus(4'b1111, 10'h3FF, 5);
      checkOutput("t5_exit_key", GPIO_1[0], 0);
      checkOutput("t5_exit_hex", HEX0, 7'b1111111);
      clearQueues();
      applyStimulus(4'b1111, 10'h3FF, 3000);
      checkOutput("t5_no_chars", edgeQ.size(), 0);

      $display("[TB] scenario 6: reset during a dash");
      clearQueues();
      applyStimulus(4'b1101, 10'h3FF, 20);
      applyStimulus(4'b1111, 10'h3FF, 100);
      applyStimulus(4'b1110, 10'h3FF, 20);
      applyStimulus(4'b1111, 10'h3FF, 100);
      checkOutput("t6_in_dash", GPIO_1[0], 1);
      RST = 1'b1;
      #1;
      checkOutput("t6_reset_gpio", GPIO_1, 0);
      checkOutput("t6_reset_hex", HEX0, 7'b1111111);
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      clearQueues();
      applyStimulus(4'b1111, 10'h3FF, 3000);
      checkOutput("t6_stays_idle", edgeQ.size(), 0);
      checkOutput("t6_hex_idle", HEX0, 7'b1111111);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
